// File: rtl/pe_stream_ctrl.sv
// rtl/pe_stream_ctrl.sv - weight/sample sequencer and result capture for one 7-tap PE
//
// Loads a K-word kernel, buffers a segment of len samples, clears the PE for one
// cycle, streams the segment with no bubbles, waits PE_LAT cycles and forwards
// the PE results as a valid-qualified stream.
//
// Optional feature macro: PE_CTRL_PERF_EN (enables the busy-cycle counter on perf_cycles).
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   start, len                  job request (len latched on accepted start)
//   w_valid/w_ready/w_data      kernel weight stream, first word -> w0
//   x_valid/x_ready/x_data      ECG sample stream
//   pe_rst, pe_xin, pe_win      PE control: active-high clear, sample, packed {w6..w0}
//   pe_sum, pe_sum1             PE results
//   o_valid, o_sum, o_sum1      captured results, no backpressure
//   busy, done, err             status: not idle, end-of-job pulse, rejected-start pulse
//   perf_cycles                 busy-cycle count of the last job (0 without the macro)
module pe_stream_ctrl #(
    parameter int N         = 32,
    parameter int SUM_WIDTH = 2*N+4,
    parameter int K         = 7,
    parameter int MAX_LEN   = 256,
    parameter int LW        = $clog2(MAX_LEN)+1,
    parameter int PE_LAT    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LW-1:0]        len,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [N-1:0]         w_data,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic [N-1:0]         x_data,
    output logic                 pe_rst,
    output logic [N-1:0]         pe_xin,
    output logic [K*N-1:0]       pe_win,
    input  logic [SUM_WIDTH-1:0] pe_sum,
    input  logic [SUM_WIDTH-1:0] pe_sum1,
    output logic                 o_valid,
    output logic [SUM_WIDTH-1:0] o_sum,
    output logic [SUM_WIDTH-1:0] o_sum1,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          perf_cycles
);

    localparam int AW = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_X, S_CLEAR, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t            state, next_state;
    logic [LW-1:0]     cnt;
    logic [LW-1:0]     len_q;
    logic              advance;
    logic              len_ok;
    logic              accept;
    logic [AW-1:0]     rd_addr;
    logic [N-1:0]      rd_data;
    logic [N-1:0]      mem [MAX_LEN];
    logic [PE_LAT-1:0] vpipe;

    assign len_ok = (len != '0) && (len <= LW'(MAX_LEN));
    assign accept = (state == S_IDLE) && start && len_ok;

    always_comb begin
        next_state = state;
        advance    = 1'b0;
        case (state)
            S_IDLE:   if (accept) next_state = S_LOAD_W;
            S_LOAD_W: begin
                advance = w_valid;
                if (w_valid && cnt == LW'(K-1)) next_state = S_LOAD_X;
            end
            S_LOAD_X: begin
                advance = x_valid;
                if (x_valid && cnt == len_q - 1'b1) next_state = S_CLEAR;
            end
            S_CLEAR:  next_state = S_STREAM;
            S_STREAM: begin
                advance = 1'b1;
                if (cnt == len_q - 1'b1) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                advance = 1'b1;
                if (cnt == LW'(PE_LAT-1)) next_state = S_DONE;
            end
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (state == S_LOAD_W);
        x_ready = (state == S_LOAD_X);
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        pe_rst  = (state == S_IDLE) || (state == S_CLEAR);
        pe_xin  = (state == S_STREAM) ? rd_data : '0;
        // Prefetch: CLEAR reads word 0, STREAM cycle k reads word k+1 for the next cycle.
        rd_addr = (state == S_STREAM) ? cnt[AW-1:0] + AW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            len_q   <= '0;
            pe_win  <= '0;
            err     <= 1'b0;
            vpipe   <= '0;
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_sum1  <= '0;
        end else begin
            state <= next_state;
            err   <= (state == S_IDLE) && start && !len_ok;
            if (accept) len_q <= len;
            // One counter serves every phase; it restarts on each state change.
            if (next_state != state) cnt <= '0;
            else if (advance)        cnt <= cnt + 1'b1;
            if (state == S_LOAD_W && w_valid) begin
                for (int i = 0; i < K; i++) begin
                    if (cnt == LW'(i)) pe_win[i*N +: N] <= w_data;
                end
            end
            // vpipe[PE_LAT-1] marks the cycle whose pe_sum belongs to a streamed sample.
            vpipe   <= {vpipe[PE_LAT-2:0], state == S_STREAM};
            o_valid <= vpipe[PE_LAT-1];
            if (vpipe[PE_LAT-1]) begin
                o_sum  <= pe_sum;
                o_sum1 <= pe_sum1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_LOAD_X && x_valid) mem[cnt[AW-1:0]] <= x_data;
        rd_data <= mem[rd_addr];
    end

`ifdef PE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst)        perf_cycles <= '0;
        else if (accept) perf_cycles <= '0;
        else if (busy)   perf_cycles <= perf_cycles + 32'd1;
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// tb/tb_pe_stream_ctrl.sv - self-checking randomized bench for pe_stream_ctrl
module tb_pe_stream_ctrl;

    localparam int N = 32, SW = 2*N+4, K = 7, MAX_LEN = 256, LW = 9, PE_LAT = 9;
    localparam int TMAX = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, w_valid, w_ready, x_valid, x_ready;
    logic [LW-1:0] len;
    logic [N-1:0]  w_data, x_data, pe_xin;
    logic          pe_rst, o_valid, busy, done, err;
    logic [K*N-1:0] pe_win;
    logic [SW-1:0] pe_sum, pe_sum1, o_sum, o_sum1;
    logic [31:0]   perf_cycles;

    pe_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .pe_rst(pe_rst), .pe_xin(pe_xin), .pe_win(pe_win),
        .pe_sum(pe_sum), .pe_sum1(pe_sum1),
        .o_valid(o_valid), .o_sum(o_sum), .o_sum1(o_sum1),
        .busy(busy), .done(done), .err(err), .perf_cycles(perf_cycles)
    );

    function automatic logic [SW-1:0] g0(input logic [N-1:0] x);
        return {4'hA, x, ~x};
    endfunction
    function automatic logic [SW-1:0] g1(input logic [N-1:0] x);
        return {x ^ 32'h5A5A5A5A, 4'h3, x};
    endfunction

    // Stand-in PE: results are a fixed function of the sample seen PE_LAT cycles ago.
    logic [N-1:0] dly [PE_LAT];
    always @(posedge clk) begin
        dly[0] <= pe_xin;
        for (int i = 1; i < PE_LAT; i++) dly[i] <= dly[i-1];
    end
    assign pe_sum  = g0(dly[PE_LAT-1]);
    assign pe_sum1 = g1(dly[PE_LAT-1]);

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic          tr_pr   [TMAX];
    logic [N-1:0]  tr_xin  [TMAX];
    logic          tr_ov   [TMAX];
    logic          tr_done [TMAX];
    logic          tr_err  [TMAX];
    logic          tr_busy [TMAX];
    logic [SW-1:0] tr_s0   [TMAX];
    logic [SW-1:0] tr_s1   [TMAX];

    task automatic run_job(input int L, input bit gaps, input bit fixed,
                           input bit inj_start, input bit abort);
        logic [N-1:0]   w [K];
        logic [N-1:0]   xs [$];
        logic [K*N-1:0] exp_win;
        int wi, xi, lx, dn, nov, nerr, nbad, last;
        bit aborted;
        xs = {};
        for (int i = 0; i < K; i++) begin
            w[i] = fixed ? N'(i + 1) : $urandom;
            exp_win[i*N +: N] = w[i];
        end
        for (int j = 0; j < L; j++) xs.push_back(fixed ? N'(j + 5) : $urandom);
        wi = 0; xi = 0; lx = -1; dn = -1; aborted = 0; last = 0;
        @(negedge clk);
        start = 1'b1;
        len   = LW'(L);
        for (int k = 0; k < TMAX; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (inj_start && lx >= 0 && k == lx + 3) begin
                start = 1'b1;
                len   = LW'(3);
            end
            if (abort && lx >= 0 && k == lx + 4) begin
                aborted = 1;
                break;
            end
            tr_pr[k] = pe_rst;  tr_xin[k] = pe_xin; tr_ov[k] = o_valid;
            tr_done[k] = done;  tr_err[k] = err;    tr_busy[k] = busy;
            tr_s0[k] = o_sum;   tr_s1[k] = o_sum1;
            last = k;
            if (done && dn < 0) dn = k;
            if (dn >= 0 && k == dn + 3) break;
            w_valid = (wi < K) && (!gaps || ($urandom_range(0, 1) == 1));
            w_data  = (wi < K) ? w[wi] : '0;
            if (w_valid && w_ready) wi++;
            x_valid = (xi < L) && (!gaps || (k % 2 == 0));
            x_data  = (xi < L) ? xs[xi] : '0;
            if (x_valid && x_ready) begin
                xi++;
                if (xi == L) lx = k;
            end
        end
        w_valid = 1'b0;
        x_valid = 1'b0;
        start   = 1'b0;

        if (aborted) begin
            rst = 1'b0;
            @(negedge clk);
            check("abort_busy", busy, 0);
            check("abort_ovalid", o_valid, 0);
            check("abort_pe_rst", pe_rst, 1);
            check("abort_xin", pe_xin, 0);
            rst = 1'b1;
            nov = 0; nbad = 0;
            for (int k = 0; k < 2*PE_LAT + 4; k++) begin
                @(negedge clk);
                nov  += o_valid;
                nbad += busy;
            end
            check("abort_no_ovalid", nov, 0);
            check("abort_stays_idle", nbad, 0);
            return;
        end

        if (dn < 0 || lx < 0) begin
            check("timeout", 0, 1);
            return;
        end
        check("win", pe_win, exp_win);
        check("clear_rst", {tr_pr[lx], tr_pr[lx+1], tr_pr[lx+2]}, 3'b010);
        check("clear_xin", tr_xin[lx+1], 0);
        nbad = 0;
        for (int j = 0; j < L; j++) begin
            check("xin", tr_xin[lx+2+j], xs[j]);
            nbad += tr_pr[lx+2+j];
        end
        for (int j = 0; j < PE_LAT; j++) nbad += (tr_xin[lx+2+L+j] != 0) || tr_pr[lx+2+L+j];
        check("stream_drain_ctrl", nbad, 0);
        check("done_at", dn, lx + 2 + L + PE_LAT);
        for (int j = 0; j < L; j++) begin
            int idx = lx + 2 + j + PE_LAT + 1;
            check("ovalid", tr_ov[idx], 1);
            check("osum", tr_s0[idx], g0(xs[j]));
            check("osum1", tr_s1[idx], g1(xs[j]));
        end
        nov = 0; nerr = 0;
        for (int k = 0; k <= last; k++) begin
            nov  += tr_ov[k];
            nerr += tr_err[k];
        end
        check("ovalid_count", nov, L);
        check("err_quiet", nerr, 0);
        check("busy_done", {tr_busy[dn], tr_busy[dn+1]}, 2'b10);
`ifdef PE_CTRL_PERF_EN
        check("perf", perf_cycles, dn + 1);
`else
        check("perf", perf_cycles, 0);
`endif
    endtask

    task automatic bad_start(input int L, input string tag);
        @(negedge clk);
        start = 1'b1;
        len   = LW'(L);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_err"}, err, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wready"}, w_ready, 0);
        @(negedge clk);
        check({tag, "_err_pulse"}, err, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; len = '0;
        w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ovalid", o_valid, 0);
        check("rst_pe_rst", pe_rst, 1);
        check("rst_xin", pe_xin, 0);
        check("rst_win", pe_win, 0);
        check("rst_ready", {w_ready, x_ready}, 0);
        check("rst_osum", {o_sum, o_sum1}, 0);
        check("rst_perf", perf_cycles, 0);
        rst = 1'b1;

        run_job(1, 0, 1, 0, 0);
        bad_start(0, "len0");
        bad_start(MAX_LEN + 1, "len_over");
        run_job(16, 1, 0, 0, 0);
        run_job(4, 0, 0, 0, 0);
        run_job(12, 0, 0, 1, 0);
        run_job(12, 0, 0, 0, 1);
        run_job(5, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) run_job($urandom_range(1, 40), $urandom_range(0, 1) == 1, 0, 0, 0);
        run_job(MAX_LEN, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
